input_debounce_sync: RTL and testbench

- Input-side conditioning block for the board's slide switches and push buttons.
- Each raw, asynchronous, bouncing input is synchronized into the clock domain and debounced.
- Per channel it outputs a clean level plus one-cycle rise and fall pulses.
- Sits between the top-level pins and any logic that drives LEDs or control from user inputs.

---
 rtl/input_debounce_sync.sv | 93 +++++++++
 tb/tb_input_debounce_sync.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_sync.sv
// input_debounce_sync: synchronizes and debounces WIDTH asynchronous switch or
// button inputs. Each channel gives a clean level plus one-cycle rise and fall
// pulses that line up with the level change.
// Optional feature macro: DEBOUNCE_TOGGLE_EN adds a toggle_out port. Each bit
// flips on the cycle after its channel's rise_pulse, for latching push-buttons.
module input_debounce_sync #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1250000,
   parameter int CNT_W           = 21
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
`ifdef DEBOUNCE_TOGGLE_EN
   ,
   output logic [WIDTH-1:0] toggle_out
`endif
);

   // Terminal count: a difference still present here is accepted on this edge.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] accept_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Per-channel counter next-state logic. Any agreement between the
   // synchronized input and the stable level clears the count, so a bounce
   // earns no partial credit. The clear on acceptance means the counter
   // never wraps.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_ch
         logic differs;
         logic at_last;
         assign differs      = sync2_q[gi] ^ stable_q[gi];
         assign at_last      = (cnt_q[gi] == CNT_LAST);
         assign accept_d[gi] = differs & at_last;
         assign cnt_d[gi]    = (differs && !at_last) ? cnt_q[gi] + 1'b1 : '0;
      end
   endgenerate

   // Two-flop synchronizer for the raw pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   // Debounce counters, stable level, and registered edge pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         stable_q <= stable_q ^ accept_d;
         rise_q   <= accept_d & sync2_q;
         fall_q   <= accept_d & ~sync2_q;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign level_out  = stable_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
   logic [WIDTH-1:0] toggle_q;

   // Latching toggle: flips one cycle after each accepted press.
   always_ff @(posedge clk) begin
      if (reset) toggle_q <= '0;
      else       toggle_q <= toggle_q ^ rise_q;
   end

   assign toggle_out = toggle_q;
`endif

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed testbench for input_debounce_sync with WIDTH=4, DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge. The next edge is therefore edge 1,
// the first edge to sample the new value. Outputs are checked 1 ns after
// the edge. With DEBOUNCE_CYCLES=4, accepted changes appear on edge 6.
module tb_input_debounce_sync;

   logic       clk;
   logic       reset;
   logic [3:0] raw_in;
   logic [3:0] level_out;
   logic [3:0] rise_pulse;
   logic [3:0] fall_pulse;
`ifdef DEBOUNCE_TOGGLE_EN
   logic [3:0] toggle_out;
`endif

   int checks = 0;
   int errors = 0;

   input_debounce_sync #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .raw_in(raw_in),
      .level_out(level_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse)
`ifdef DEBOUNCE_TOGGLE_EN
      ,
      .toggle_out(toggle_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [3:0] lvl, input logic [3:0] rse,
                       input logic [3:0] fll);
      chk({tag, ".level"}, level_out, lvl);
      chk({tag, ".rise"}, rise_pulse, rse);
      chk({tag, ".fall"}, fall_pulse, fll);
   endtask

   initial begin
      bit pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

      clk    = 1'b0;
      reset  = 1'b1;
      raw_in = 4'hF;

      // Reset held three cycles with all inputs high: every output stays 0.
      for (int i = 0; i < 3; i++) begin
         step();
         chk3("reset", 4'h0, 4'h0, 4'h0);
`ifdef DEBOUNCE_TOGGLE_EN
         chk("reset.toggle", toggle_out, 4'h0);
`endif
      end
      reset = 1'b0;
      steps(5);
      chk("rst_release.e5", level_out, 4'h0);
      step();
      chk3("rst_release.e6", 4'hF, 4'hF, 4'h0);
      step();
      chk3("rst_release.e7", 4'hF, 4'h0, 4'h0);
      $display("txn reset release: level F with rise F on edge 6");

      // All channels fall together.
      raw_in = 4'h0;
      steps(5);
      chk("all_fall.e5", level_out, 4'hF);
      step();
      chk3("all_fall.e6", 4'h0, 4'h0, 4'hF);
      step();
      chk3("all_fall.e7", 4'h0, 4'h0, 4'h0);
      $display("txn all fall: level 0 with fall F on edge 6");

      // Clean step up and down on channel 0.
      raw_in = 4'h1;
      steps(5);
      chk("clean_rise.e5", level_out, 4'h0);
      step();
      chk3("clean_rise.e6", 4'h1, 4'h1, 4'h0);
      step();
      chk3("clean_rise.e7", 4'h1, 4'h0, 4'h0);
      raw_in = 4'h0;
      steps(5);
      chk("clean_fall.e5", level_out, 4'h1);
      step();
      chk3("clean_fall.e6", 4'h0, 4'h0, 4'h1);
      step();
      chk3("clean_fall.e7", 4'h0, 4'h0, 4'h0);
      $display("txn clean step ch0: rise and fall pulses on edge 6");

      // A 3-cycle glitch on channel 1 is rejected.
      raw_in = 4'h2;
      steps(3);
      raw_in = 4'h0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk3("glitch3", 4'h0, 4'h0, 4'h0);
      end
      $display("txn glitch 3 cycles ch1: rejected");

      // A 4-cycle pulse on channel 1 is accepted and then released.
      // The release is first sampled on edge 5, so the fall lands on edge 10.
      raw_in = 4'h2;
      steps(4);
      raw_in = 4'h0;
      step();
      chk3("pulse4.e5", 4'h0, 4'h0, 4'h0);
      step();
      chk3("pulse4.e6", 4'h2, 4'h2, 4'h0);
      steps(3);
      chk3("pulse4.e9", 4'h2, 4'h0, 4'h0);
      step();
      chk3("pulse4.e10", 4'h0, 4'h0, 4'h2);
      step();
      chk3("pulse4.e11", 4'h0, 4'h0, 4'h0);
      $display("txn pulse 4 cycles ch1: rise edge 6, fall edge 10");

      // Bounce on channel 2. Only the final run of 1s, starting at edge 6,
      // is accepted, so the change lands on edge 11.
      for (int i = 0; i < 9; i++) begin
         raw_in = pat[i] ? 4'h4 : 4'h0;
         step();
         chk3("bounce.pre", 4'h0, 4'h0, 4'h0);
      end
      step();
      chk3("bounce.e10", 4'h0, 4'h0, 4'h0);
      step();
      chk3("bounce.e11", 4'h4, 4'h4, 4'h0);
      step();
      chk3("bounce.e12", 4'h4, 4'h0, 4'h0);
      $display("txn bounce ch2: single rise on edge 11");

      // Bring channel 3 high, then raise ch0 and drop ch3 in the same cycle.
      raw_in = 4'hC;
      steps(5);
      chk("ch3_rise.e5", level_out, 4'h4);
      step();
      chk3("ch3_rise.e6", 4'hC, 4'h8, 4'h0);
      step();
      chk3("ch3_rise.e7", 4'hC, 4'h0, 4'h0);
      raw_in = 4'h5;
      steps(5);
      chk("simul.e5", level_out, 4'hC);
      step();
      chk3("simul.e6", 4'h5, 4'h1, 4'h8);
      step();
      chk3("simul.e7", 4'h5, 4'h0, 4'h0);
      $display("txn simultaneous: rise ch0 and fall ch3 on the same edge");

      // Reset during a count on ch1 discards progress. After release, all
      // high inputs need the full latency again.
      raw_in = 4'h7;
      steps(3);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk3("midreset.in", 4'h0, 4'h0, 4'h0);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk3("midreset.post", 4'h0, 4'h0, 4'h0);
      end
      step();
      chk3("midreset.e6", 4'h7, 4'h7, 4'h0);
      step();
      chk3("midreset.e7", 4'h7, 4'h0, 4'h0);
      $display("txn reset mid-count: count restarted, rise 7 on edge 6");

`ifdef DEBOUNCE_TOGGLE_EN
      // Clear everything, then press channel 0 three times.
      raw_in = 4'h0;
      reset  = 1'b1;
      steps(2);
      chk("tog.reset", toggle_out, 4'h0);
      reset = 1'b0;
      steps(8);
      chk("tog.idle", toggle_out, 4'h0);
      for (int p = 0; p < 3; p++) begin
         logic [3:0] tog_exp;
         tog_exp = (p % 2 == 0) ? 4'h1 : 4'h0;
         raw_in = 4'h1;
         steps(6);
         chk("tog.press_rise", rise_pulse, 4'h1);
         chk("tog.before", toggle_out, tog_exp ^ 4'h1);
         step();
         chk("tog.after", toggle_out, tog_exp);
         raw_in = 4'h0;
         steps(6);
         chk("tog.release_fall", fall_pulse, 4'h1);
         steps(2);
         chk("tog.release_hold", toggle_out, tog_exp);
         $display("txn toggle press %0d: toggle_out %h", p, toggle_out);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
